// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage:
// op codes, FSM state encoding and default datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit-per-cycle shifter: work register,
// down-counter and a last-step indication.
module alu_shift_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] din,
    input  logic [SHW-1:0]  amt,
    output logic [XLEN-1:0] work_nxt,
    output logic            done
);
    import alu_pkg::*;

    logic [XLEN-1:0] work;
    logic [SHW-1:0]  count;
    logic [3:0]      mode;

    // One-bit shift of the work register according to the latched mode
    always_comb begin
        work_nxt = work;
        unique case (1'b1)
            (mode == ALU_SLL): work_nxt = {work[XLEN-2:0], 1'b0};
            (mode == ALU_SRL): work_nxt = {1'b0, work[XLEN-1:1]};
            (mode == ALU_SRA): work_nxt = {work[XLEN-1], work[XLEN-1:1]};
            default:           work_nxt = work;
        endcase
    end

    // The step that takes count from 1 to 0 is the final one
    assign done = (count == SHW'(1));

    // Load on accept, then shift and count down until exhausted
    always_ff @(posedge clk) begin
        if (rst) begin
            work  <= '0;
            count <= '0;
            mode  <= ALU_SLL;
        end else if (load) begin
            work  <= din;
            count <= amt;
            mode  <= op;
        end else if (count != '0) begin
            work  <= work_nxt;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready handshakes
// and an iterative shifter for SLL/SRL/SRA.
module alu_exec_unit #(
    parameter int XLEN = alu_pkg::XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    import alu_pkg::*;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] cap_val;
    logic            cap;
    logic            load;
    logic            sh_done;
    logic [XLEN-1:0] sh_next;
    logic [SHW-1:0]  shamt;

    assign shamt = operand_b[SHW-1:0];

    alu_shift_iter #(
        .XLEN(XLEN),
        .SHW (SHW)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .op      (alu_ctrl),
        .din     (operand_a),
        .amt     (shamt),
        .work_nxt(sh_next),
        .done    (sh_done)
    );

    // Single-cycle logical/arithmetic datapath
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND: alu_res = operand_a & operand_b;
            ALU_OR:  alu_res = operand_a | operand_b;
            ALU_XOR: alu_res = operand_a ^ operand_b;
            ALU_NOR: alu_res = ~(operand_a | operand_b);
            ALU_ADD: alu_res = operand_a + operand_b;
            ALU_SUB: alu_res = operand_a - operand_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}},
                                ($signed(operand_a) < $signed(operand_b))};
            default: alu_res = '0;
        endcase
    end

    // Next-state, handshake outputs and result capture control
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        cap       = 1'b0;
        cap_val   = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_shift(alu_ctrl)) begin
                        load = 1'b1;
                        if (shamt == '0) begin
                            cap     = 1'b1;
                            cap_val = operand_a;
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        cap     = 1'b1;
                        cap_val = alu_res;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (sh_done) begin
                    cap     = 1'b1;
                    cap_val = sh_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result and zero flag change only when a new result is captured
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
        end else if (cap) begin
            result <= cap_val;
            zero   <= (cap_val == '0);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit.
module tb_alu_exec_unit;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_UNK = 4'b0101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then count edges until out_valid
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        in_valid  = 1'b1;
        alu_ctrl  = op;
        operand_a = a;
        operand_b = b;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 1000",
                     {in_ready, out_valid, busy, zero});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
    endtask

    task automatic test_reset_mid_shift();
        in_valid  = 1'b1;
        alu_ctrl  = OP_SLL;
        operand_a = 32'h1;
        operand_b = 32'd20;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({busy, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midshift_busy: got %b expected 10",
                     {busy, in_ready});
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midshift_reset_flags: got %b expected 1000",
                     {in_ready, out_valid, busy, zero});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL midshift_reset_result: got %h expected 0", result);
        end
    endtask

    task automatic test_arith();
        int lat;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd1, 32'h8000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL add: got lat=%0d res=%h z=%b expected 1 80000000 0",
                     lat, result, zero);
        end
        drain();
        run_op(OP_SUB, 32'd5, 32'd5, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub: got lat=%0d res=%h z=%b expected 1 0 1",
                     lat, result, zero);
        end
        drain();
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd1, 32'h1, 1'b0}) begin
            n_fail++;
            $display("FAIL slt: got lat=%0d res=%h z=%b expected 1 1 0",
                     lat, result, zero);
        end
        drain();
        run_op(OP_SLT, 32'h1, 32'hFFFF_FFFF, lat);
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL slt_false: got %h expected 0", result);
        end
        drain();
    endtask

    task automatic test_logic();
        int lat;
        run_op(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
        n_checks++;
        if (result !== 32'h0F00_0F00) begin
            n_fail++;
            $display("FAIL and: got %h expected 0f000f00", result);
        end
        drain();
        run_op(OP_NOR, 32'h0, 32'h0, lat);
        n_checks++;
        if (result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL nor: got %h expected ffffffff", result);
        end
        drain();
        run_op(OP_UNK, 32'h1234_5678, 32'h1, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL unknown: got lat=%0d res=%h z=%b expected 1 0 1",
                     lat, result, zero);
        end
        drain();
    endtask

    task automatic test_shifts();
        int lat;
        run_op(OP_SLL, 32'h1, 32'd31, lat);
        n_checks++;
        if ({lat, result} !== {32'd32, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL sll31: got lat=%0d res=%h expected 32 80000000",
                     lat, result);
        end
        drain();
        run_op(OP_SRA, 32'h8000_0000, 32'd4, lat);
        n_checks++;
        if ({lat, result} !== {32'd5, 32'hF800_0000}) begin
            n_fail++;
            $display("FAIL sra4: got lat=%0d res=%h expected 5 f8000000",
                     lat, result);
        end
        drain();
        run_op(OP_SRL, 32'h8000_0000, 32'd4, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd5, 32'h0800_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL srl4: got lat=%0d res=%h z=%b expected 5 08000000 0",
                     lat, result, zero);
        end
        drain();
        run_op(OP_SLL, 32'h1234_5678, 32'h20, lat);
        n_checks++;
        if ({lat, result} !== {32'd1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL shift0: got lat=%0d res=%h expected 1 12345678",
                     lat, result);
        end
        drain();
        run_op(OP_SRL, 32'h0000_0004, 32'hFFFF_FFE3, lat);
        n_checks++;
        if ({lat, result, zero} !== {32'd4, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL srl_hibits: got lat=%0d res=%h z=%b expected 4 0 1",
                     lat, result, zero);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({result, out_valid, in_ready} !== {32'hF0F0_0F0F, 2'b10})
                bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d bad cycles expected 0",
                     bad);
        end
        drain();
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL backpressure_release: got %b expected 100",
                     {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        int early;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        alu_ctrl  = OP_SRL;
        operand_a = 32'h80;
        operand_b = 32'd3;
        tick();
        alu_ctrl  = OP_ADD;
        operand_a = 32'd2;
        operand_b = 32'd3;
        early = 0;
        tick();
        if (in_ready !== 1'b0) early++;
        tick();
        if (in_ready !== 1'b0) early++;
        tick();
        n_checks++;
        if ({out_valid, in_ready, result} !== {2'b10, 32'h10}) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b r=%b res=%h expected 1 0 10",
                     out_valid, in_ready, result);
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL b2b_ready_busy: got %0d expected 0", early);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected 10",
                     {in_ready, out_valid});
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b res=%h expected 1 5",
                     out_valid, result);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got %b expected 1", in_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'h0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        test_reset();
        test_reset_mid_shift();
        test_arith();
        test_logic();
        test_shifts();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
